// File: rtl/tag_dir_replace_client_pkg.sv
// Shared types for the tag directory: controller state and per-way tag entry.
package tag_dir_replace_client_pkg;

  localparam int TAG_W = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    VICTIM = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/tag_dir_replace_client_tag_way_match.sv
// Combinational tag compare across one set; lowest-numbered way wins for both
// the match and the first free way.
module tag_way_match
  import tag_dir_replace_client_pkg::*;
#(
  parameter int WAY_NUM   = 4,
  parameter int WAY_WIDTH = $clog2(WAY_NUM)
) (
  input  tag_entry_t           entries [WAY_NUM],
  input  logic [TAG_W-1:0]     tag,
  output logic                 hit,
  output logic [WAY_WIDTH-1:0] hit_way,
  output logic                 any_invalid,
  output logic [WAY_WIDTH-1:0] first_invalid_way
);

  always_comb begin
    hit               = 1'b0;
    hit_way           = '0;
    any_invalid       = 1'b0;
    first_invalid_way = '0;
    // Descending scan so the lowest way is the last (winning) assignment.
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (entries[w].valid && (entries[w].tag == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
      if (!entries[w].valid) begin
        any_invalid       = 1'b1;
        first_invalid_way = WAY_WIDTH'(w);
      end
    end
  end

endmodule

// File: rtl/tag_dir_replace_client.sv
// Set-associative tag directory driving the replacement policy's hit/miss
// interface: MRU updates on hit/install, victim taken from the policy on full-set miss.
module tag_dir_replace_client
  import tag_dir_replace_client_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int WAY_NUM    = 4,
  parameter int TAG_WIDTH  = TAG_W,
  parameter int WAY_WIDTH  = $clog2(WAY_NUM),
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_index,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  req_alloc,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_hit,
  output logic [WAY_WIDTH-1:0]  resp_way,
  output logic                  resp_evict_valid,
  output logic [TAG_WIDTH-1:0]  resp_evict_tag,
  input  logic                  inv_en,
  input  logic [ADDR_WIDTH-1:0] inv_index,
  input  logic [WAY_WIDTH-1:0]  inv_way,
  output logic                  hit_en,
  output logic [ADDR_WIDTH-1:0] hit_index,
  output logic [WAY_WIDTH-1:0]  hit_way,
  output logic [ADDR_WIDTH-1:0] miss_index,
  input  logic [WAY_WIDTH-1:0]  miss_way
);

  state_t                state_q, state_d;
  logic [WAY_NUM-1:0]    valid_q [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q   [DEPTH][WAY_NUM];
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [TAG_WIDTH-1:0]  req_tag_q;
  logic                  alloc_q;
  logic                  install;

  tag_entry_t            set_entries [WAY_NUM];
  logic                  m_hit, m_any_inv;
  logic [WAY_WIDTH-1:0]  m_way, m_first_inv;

  always_comb begin
    for (int w = 0; w < WAY_NUM; w++) begin
      set_entries[w].valid = valid_q[idx_q][w];
      set_entries[w].tag   = tag_q[idx_q][w];
    end
  end

  tag_way_match #(
    .WAY_NUM   (WAY_NUM),
    .WAY_WIDTH (WAY_WIDTH)
  ) u_match (
    .entries           (set_entries),
    .tag               (req_tag_q),
    .hit               (m_hit),
    .hit_way           (m_way),
    .any_invalid       (m_any_inv),
    .first_invalid_way (m_first_inv)
  );

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign miss_index = idx_q;

  always_comb begin
    state_d   = state_q;
    hit_en    = 1'b0;
    hit_way   = '0;
    hit_index = '0;
    install   = 1'b0;
    case (state_q)
      IDLE:   if (req_valid) state_d = LOOKUP;
      LOOKUP: begin
        state_d = RESP;
        if (m_hit) begin
          hit_en  = 1'b1;
          hit_way = m_way;
        end else if (alloc_q) begin
          if (m_any_inv) begin
            hit_en  = 1'b1;
            hit_way = m_first_inv;
            install = 1'b1;
          end else begin
            state_d = VICTIM;
          end
        end
      end
      VICTIM: begin
        hit_en  = 1'b1;
        hit_way = miss_way;
        install = 1'b1;
        state_d = RESP;
      end
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (hit_en) hit_index = idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture: index feeds miss_index so it is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else if (req_valid && req_ready) idx_q <= req_index;
  end

  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      req_tag_q <= req_tag;
      alloc_q   <= req_alloc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_hit         <= 1'b0;
      resp_way         <= '0;
      resp_evict_valid <= 1'b0;
      resp_evict_tag   <= '0;
    end else if (state_q == LOOKUP) begin
      resp_hit         <= m_hit;
      resp_way         <= m_hit ? m_way : ((alloc_q && m_any_inv) ? m_first_inv : '0);
      resp_evict_valid <= 1'b0;
      resp_evict_tag   <= '0;
    end else if (state_q == VICTIM) begin
      resp_way         <= miss_way;
      resp_evict_valid <= 1'b1;
      resp_evict_tag   <= tag_q[idx_q][miss_way];
    end
  end

  // Install is written after invalidate so a same-way collision keeps the line valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) valid_q[s] <= '0;
    end else begin
      if (inv_en)  valid_q[inv_index][inv_way] <= 1'b0;
      if (install) valid_q[idx_q][hit_way]     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (install) tag_q[idx_q][hit_way] <= req_tag_q;
  end

endmodule

// File: tb/tb_tag_dir_replace_client.sv
// Directed plus randomized bench for tag_dir_replace_client with a set/way
// reference model and a stub replacement policy supplying miss_way.
module tb_tag_dir_replace_client;
  localparam int DEPTH = 64, WAY_NUM = 4, TAG_WIDTH = 20, WAY_WIDTH = 2, ADDR_WIDTH = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0, req_ready, req_alloc = 1'b0;
  logic [ADDR_WIDTH-1:0] req_index = '0;
  logic [TAG_WIDTH-1:0]  req_tag = '0;
  logic                  resp_valid, resp_ready = 1'b0, resp_hit, resp_evict_valid;
  logic [WAY_WIDTH-1:0]  resp_way;
  logic [TAG_WIDTH-1:0]  resp_evict_tag;
  logic                  inv_en = 1'b0;
  logic [ADDR_WIDTH-1:0] inv_index = '0;
  logic [WAY_WIDTH-1:0]  inv_way = '0;
  logic                  hit_en;
  logic [ADDR_WIDTH-1:0] hit_index, miss_index;
  logic [WAY_WIDTH-1:0]  hit_way, miss_way = '0;

  tag_dir_replace_client dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_tag(req_tag), .req_alloc(req_alloc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_way(resp_way), .resp_evict_valid(resp_evict_valid), .resp_evict_tag(resp_evict_tag),
    .inv_en(inv_en), .inv_index(inv_index), .inv_way(inv_way),
    .hit_en(hit_en), .hit_index(hit_index), .hit_way(hit_way),
    .miss_index(miss_index), .miss_way(miss_way)
  );

  int total = 0, bad = 0;
  bit              m_valid [DEPTH][WAY_NUM];
  logic [19:0]     m_tag   [DEPTH][WAY_NUM];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < DEPTH; s++)
      for (int w = 0; w < WAY_NUM; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic do_inv(input int idx, input int w);
    @(negedge clk);
    inv_en = 1'b1; inv_index = ADDR_WIDTH'(idx); inv_way = WAY_WIDTH'(w);
    @(posedge clk);
    #1 inv_en = 1'b0;
    m_valid[idx][w] = 1'b0;
  endtask

  // One lookup transaction; expected values come from the set/way model.
  task automatic run_req(input string nm, input int idx, input logic [19:0] tg, input bit al,
                         input int mw, input int hold, input bit inv_lk, input int inv_w,
                         input bit rst_in_resp);
    int nmatch, ew, elat, lat, hc, hidx, hw, fi;
    bit eh, eev, inst;
    logic [19:0] etag;
    nmatch = 0; eh = 0; ew = 0; eev = 0; etag = '0; elat = 2; inst = 0; fi = -1;
    for (int w = 0; w < WAY_NUM; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tg) begin
        nmatch++;
        if (!eh) begin eh = 1; ew = w; end
      end
    total++;
    assert (nmatch <= 1) else begin
      bad++;
      $error("FAIL %s_multi_match observed=%0d expected<=1", nm, nmatch);
    end
    if (!eh && al) begin
      for (int w = WAY_NUM - 1; w >= 0; w--) if (!m_valid[idx][w]) fi = w;
      inst = 1;
      if (fi >= 0) ew = fi;
      else begin ew = mw; eev = 1; etag = m_tag[idx][mw]; elat = 3; end
    end

    @(negedge clk);
    req_valid = 1'b1; req_index = ADDR_WIDTH'(idx); req_tag = tg; req_alloc = al;
    miss_way = WAY_WIDTH'(mw);
    chk({nm, "_req_ready"}, 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0; req_index = ADDR_WIDTH'($urandom); req_tag = TAG_WIDTH'($urandom);
    if (inv_lk) begin inv_en = 1'b1; inv_index = ADDR_WIDTH'(idx); inv_way = WAY_WIDTH'(inv_w); end
    lat = 1; hc = 0; hidx = 0; hw = 0;
    while (1) begin
      @(negedge clk);
      if (hit_en) begin hc++; hidx = int'(hit_index); hw = int'(hit_way); end
      if (resp_valid || lat >= 6) break;
      @(posedge clk);
      #1 inv_en = 1'b0;
      lat++;
    end
    inv_en = 1'b0;
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_resp_hit"}, 32'(resp_hit), 32'(eh));
    chk({nm, "_resp_way"}, 32'(resp_way), 32'(ew));
    chk({nm, "_evict_valid"}, 32'(resp_evict_valid), 32'(eev));
    if (eev) chk({nm, "_evict_tag"}, 32'(resp_evict_tag), 32'(etag));
    chk({nm, "_hit_en_count"}, 32'(hc), (eh || inst) ? 1 : 0);
    if (eh || inst) begin
      chk({nm, "_hit_index"}, 32'(hidx), 32'(idx));
      chk({nm, "_hit_way"}, 32'(hw), 32'(ew));
    end
    chk({nm, "_miss_index"}, 32'(miss_index), 32'(idx));

    if (inv_lk) m_valid[idx][inv_w] = 1'b0;
    if (inst) begin m_valid[idx][ew] = 1'b1; m_tag[idx][ew] = tg; end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(resp_valid), 1);
      chk({nm, "_hold_req_ready"}, 32'(req_ready), 0);
      chk({nm, "_hold_hit_en"}, 32'(hit_en), 0);
      chk({nm, "_hold_hit"}, 32'(resp_hit), 32'(eh));
      chk({nm, "_hold_way"}, 32'(resp_way), 32'(ew));
      chk({nm, "_hold_evict"}, 32'(resp_evict_valid), 32'(eev));
    end

    if (rst_in_resp) begin
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_rst_resp_valid"}, 32'(resp_valid), 0);
      chk({nm, "_rst_req_ready"}, 32'(req_ready), 0);
      chk({nm, "_rst_hit_en"}, 32'(hit_en), 0);
      rst = 1'b0;
      model_clear();
    end else begin
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
    @(negedge clk);
    chk({nm, "_back_idle"}, 32'(req_ready), 1);
    chk({nm, "_resp_dropped"}, 32'(resp_valid), 0);
  endtask

  initial begin
    int idx, w;
    logic [19:0] tg;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_hit_en", 32'(hit_en), 0);
    chk("rst_resp_hit", 32'(resp_hit), 0);
    chk("rst_resp_way", 32'(resp_way), 0);
    chk("rst_evict_valid", 32'(resp_evict_valid), 0);
    chk("rst_evict_tag", 32'(resp_evict_tag), 0);
    chk("rst_miss_index", 32'(miss_index), 0);
    chk("rst_hit_index", 32'(hit_index), 0);
    rst = 1'b0;

    run_req("alloc_empty", 5, 20'h123, 1, 0, 0, 0, 0, 0);
    run_req("rehit", 5, 20'h123, 1, 0, 0, 0, 0, 0);
    do_inv(5, 0);
    for (int i = 0; i < 4; i++) run_req("fill", 5, 20'h10 + 20'(i), 1, 0, 0, 0, 0, 0);
    run_req("victim", 5, 20'h20, 1, 2, 0, 0, 0, 0);
    run_req("evicted_miss", 5, 20'h12, 0, 0, 0, 0, 0, 0);
    run_req("noalloc_full", 5, 20'h55, 0, 1, 0, 0, 0, 0);
    run_req("keep_w0", 5, 20'h10, 0, 0, 0, 0, 0, 0);
    run_req("keep_w1", 5, 20'h11, 0, 0, 0, 0, 0, 0);
    run_req("keep_w2", 5, 20'h20, 0, 0, 0, 0, 0, 0);
    run_req("keep_w3", 5, 20'h13, 0, 0, 0, 0, 0, 0);
    do_inv(5, 1);
    run_req("alloc_after_inv", 5, 20'h30, 1, 3, 0, 0, 0, 0);
    do_inv(5, 3);
    run_req("inv_vs_install", 5, 20'h31, 1, 0, 0, 1, 3, 0);
    run_req("install_won", 5, 20'h31, 0, 0, 0, 0, 0, 0);
    run_req("hold", 5, 20'h30, 0, 0, 4, 0, 0, 0);
    run_req("rst_in_resp", 5, 20'h10, 0, 0, 0, 0, 0, 1);
    run_req("post_rst_a", 5, 20'h30, 0, 0, 0, 0, 0, 0);
    run_req("post_rst_b", 5, 20'h20, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      idx = int'($urandom_range(0, 3));
      tg  = 20'h100 + 20'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) do_inv(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      w = int'($urandom_range(0, 3));
      run_req("rand", idx, tg, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0), w, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tag_dir_replace_client.md
Name: tag_dir_replace_client

Overview:
- Set-associative tag directory that acts as the client of the replacement-policy interface. It is the initiator side of the ReplaceIO hit/miss protocol.
- Accepts lookup requests (index, tag) and compares the tag against per-set tag/valid storage.
- On a hit, sends the MRU update to the policy. On an allocating miss, takes a victim from the lowest invalid way or from the policy's registered miss_way, installs the new tag and reports the evicted tag.
- Sits between the cache pipeline front end and the refill/writeback logic.

Parameters:
- DEPTH, 64, number of sets.
- WAY_NUM, 4, associativity; must match the policy instance.
- TAG_WIDTH, 20, tag bits.
- WAY_WIDTH, $clog2(WAY_NUM), way index width.
- ADDR_WIDTH, $clog2(DEPTH), set index width.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  directory can accept a request.
- req_index  in  ADDR_WIDTH  set index.
- req_tag  in  TAG_WIDTH  lookup tag.
- req_alloc  in  1  allocate on miss.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_hit  out  1  tag matched a valid way.
- resp_way  out  WAY_WIDTH  hit way or allocated way.
- resp_evict_valid  out  1  the allocated way held a valid line.
- resp_evict_tag  out  TAG_WIDTH  tag of the evicted line.
- inv_en  in  1  invalidate one way.
- inv_index  in  ADDR_WIDTH  invalidate set.
- inv_way  in  WAY_WIDTH  invalidate way.
- hit_en  out  1  policy update strobe.
- hit_index  out  ADDR_WIDTH  policy update set.
- hit_way  out  WAY_WIDTH  way to mark most-recently-used.
- miss_index  out  ADDR_WIDTH  set whose victim is requested.
- miss_way  in  WAY_WIDTH  victim way from the policy; registered by the policy, valid one cycle after miss_index.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; all valid bits cleared; tags are don't-care.
  - req_ready=0 while rst is high.
  - resp_valid=0, hit_en=0; other outputs are 0.
- FSM states: IDLE, LOOKUP, VICTIM, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, capture index/tag/alloc into registers; next state is LOOKUP.
- miss_index always equals the captured index register, so the policy has miss_way ready in the cycle after LOOKUP.
- LOOKUP (one cycle): compare against every way of the captured set, using the storage state before this edge.
  - Hit (exactly one match): hit_en=1, hit_index=idx, hit_way=match. resp_hit=1, resp_way=match, resp_evict_valid=0. Next state RESP.
  - Miss, alloc=0: hit_en=0, resp_hit=0, resp_way=0. Next state RESP.
  - Miss, alloc=1, some way invalid: pick the lowest-numbered invalid way. Write tag, set valid, and drive hit_en=1 for that way. resp_evict_valid=0. Next state RESP.
  - Miss, alloc=1, set full: hit_en=0. Next state VICTIM.
- VICTIM (one cycle): sample miss_way as V.
  - resp_evict_valid=1, resp_evict_tag=tag[idx][V].
  - Write the new tag into way V (valid stays 1); drive hit_en=1 with hit_way=V.
  - resp_way=V. Next state RESP.
- RESP: hold resp_valid=1 and all resp_* stable until resp_ready. Then go to IDLE; a new request can be accepted in the following cycle.
- Latency from the accept edge to resp_valid:
  - hit / non-alloc miss / invalid-way allocation: 2 cycles.
  - full-set miss: 3 cycles.
- hit_en is asserted for exactly one cycle per lookup that hits or allocates; never in IDLE or RESP.
- Invalidate:
  - Accepted in any state; clears valid[inv_index][inv_way] at the edge.
  - If an install to the same set and way happens in the same cycle, the install wins (valid=1).
  - An invalidate of the set under lookup does not change the in-flight result; LOOKUP uses the state before the edge.
- Multiple matching valid ways is illegal. The design takes the lowest-numbered match; the bench asserts it never occurs.
- rst mid-operation returns to IDLE at the next edge and drops resp_valid; pending results are lost.

Decomposition:
- Shared package:
  - state enum (IDLE/LOOKUP/VICTIM/RESP);
  - tag entry struct {valid, tag}.
- Sub-module tag_way_match: combinational, takes the set's entries and the request tag, and outputs hit, hit_way, any_invalid and first_invalid_way.

Test Plan:
- Reset, then lookup idx=5 tag=0x123 alloc=1 on an empty set -> resp 2 cycles later: hit=0, way=0, evict_valid=0; hit_en=1 with hit_index=5, hit_way=0 in the LOOKUP cycle.
- Repeat the same request -> resp_hit=1, way=0, evict_valid=0; one-cycle hit_en with way 0.
- Fill idx=5 ways 0..3 with tags 0x10..0x13, then request tag 0x20 alloc=1 with the policy model returning miss_way=2 -> VICTIM visited, resp 3 cycles after accept: way=2, evict_valid=1, evict_tag=0x12; a later lookup of 0x12 misses.
- Miss with alloc=0 on the full set -> resp_hit=0, hit_en never asserted, storage unchanged.
- inv_en idx=5 way=1 while idle, then alloc tag 0x30 -> installs in way 1 with no VICTIM state; inv and install to the same set/way in the same cycle -> valid stays 1.
- Hold resp_ready=0 for 4 cycles -> resp_* stable and req_ready=0 throughout; assert rst during RESP -> resp_valid=0 next cycle and all sets report a miss.
